// File: rtl/exe_arb_pkg.sv
// Shared definitions for the two-requester execution-unit arbiter.
//   arb_state_t : arbiter FSM encoding (IDLE -> EXEC -> CAPT -> RESP -> IDLE)
//   NUM_REQ     : number of requesters sharing the execution unit
package exe_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2,
    RESP = 2'd3
  } arb_state_t;

  localparam int NUM_REQ = 2;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin arbiter.
// Ports:
//   i_valid [1:0] : request vector
//   i_ptr         : index of the most recently granted requester
//   o_grant [1:0] : one-hot grant, or zero when nothing is requested
// With a single request that request wins; with both requesting, the
// requester that was not granted last wins.
module rr_arbiter2
  import exe_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic               i_ptr,
  output logic [NUM_REQ-1:0] o_grant
);

  always_comb begin
    o_grant = '0;
    case (i_valid)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = i_ptr ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/exe_unit_arbiter.sv
// Shares one exe_unit_w1 between two requesters.
// Ports:
//   i_clk, i_rsn                  : clock, synchronous active-low reset
//   i_req_valid / o_req_ready     : per-requester request handshake
//   i_req_{oper,argA,argB}{0,1}   : per-requester operation fields
//   o_exe_{oper,argA,argB}        : operands to the execution unit
//   i_exe_result, i_exe_status    : registered result/status from the unit
//   o_rsp_* / i_rsp_ready         : tagged response channel
//   o_busy                        : FSM is outside IDLE
//
// Handshakes: a request k transfers on a posedge where i_req_valid[k] and
// o_req_ready[k] are both 1; requesters hold their fields stable until
// then. A response transfers on a posedge where o_rsp_valid and
// i_rsp_ready are both 1; response fields stay stable until that edge.
// o_req_ready is only ever nonzero in IDLE, so an accepted response and a
// new grant never share a cycle.
module exe_unit_arbiter
  import exe_arb_pkg::*;
#(
  parameter int m = 4,
  parameter int n = 2
) (
  input  logic               i_clk,
  input  logic               i_rsn,
  input  logic [NUM_REQ-1:0] i_req_valid,
  input  logic [n-1:0]       i_req_oper0,
  input  logic [m-1:0]       i_req_argA0,
  input  logic [m-1:0]       i_req_argB0,
  input  logic [n-1:0]       i_req_oper1,
  input  logic [m-1:0]       i_req_argA1,
  input  logic [m-1:0]       i_req_argB1,
  output logic [NUM_REQ-1:0] o_req_ready,
  output logic [n-1:0]       o_exe_oper,
  output logic [m-1:0]       o_exe_argA,
  output logic [m-1:0]       o_exe_argB,
  input  logic [m-1:0]       i_exe_result,
  input  logic [1:0]         i_exe_status,
  output logic               o_rsp_valid,
  output logic               o_rsp_id,
  output logic [m-1:0]       o_rsp_result,
  output logic [1:0]         o_rsp_status,
  input  logic               i_rsp_ready,
  output logic               o_busy
);

  arb_state_t state_q, state_d;
  logic       ptr_q, ptr_d;
  logic       owner_q, owner_d;
  logic [n-1:0] oper_q, oper_d;
  logic [m-1:0] arga_q, arga_d;
  logic [m-1:0] argb_q, argb_d;
  logic         rsp_valid_q, rsp_valid_d;
  logic         rsp_id_q, rsp_id_d;
  logic [m-1:0] rsp_result_q, rsp_result_d;
  logic [1:0]   rsp_status_q, rsp_status_d;

  logic [NUM_REQ-1:0] grant;

  rr_arbiter2 u_rr (
    .i_valid (i_req_valid),
    .i_ptr   (ptr_q),
    .o_grant (grant)
  );

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    owner_d      = owner_q;
    oper_d       = oper_q;
    arga_d       = arga_q;
    argb_d       = argb_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_status_d = rsp_status_q;

    case (state_q)
      IDLE: begin
        if (grant != '0) begin
          // grant is one-hot here, so bit 1 is the owner index.
          owner_d = grant[1];
          ptr_d   = grant[1];
          oper_d  = grant[1] ? i_req_oper1 : i_req_oper0;
          arga_d  = grant[1] ? i_req_argA1 : i_req_argA0;
          argb_d  = grant[1] ? i_req_argB1 : i_req_argB0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        // Exe unit registers its result at the end of this cycle.
        state_d = CAPT;
      end
      CAPT: begin
        rsp_result_d = i_exe_result;
        rsp_status_d = i_exe_status;
        rsp_id_d     = owner_q;
        rsp_valid_d  = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        if (i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rsn) begin
      state_q      <= IDLE;
      ptr_q        <= 1'b1;
      owner_q      <= 1'b0;
      oper_q       <= '0;
      arga_q       <= '0;
      argb_q       <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_status_q <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      oper_q       <= oper_d;
      arga_q       <= arga_d;
      argb_q       <= argb_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_status_q <= rsp_status_d;
    end
  end

  assign o_req_ready  = (state_q == IDLE) ? grant : '0;
  assign o_busy       = (state_q != IDLE);
  assign o_exe_oper   = oper_q;
  assign o_exe_argA   = arga_q;
  assign o_exe_argB   = argb_q;
  assign o_rsp_valid  = rsp_valid_q;
  assign o_rsp_id     = rsp_id_q;
  assign o_rsp_result = rsp_result_q;
  assign o_rsp_status = rsp_status_q;

endmodule

// File: tb/tb_exe_unit_arbiter.sv
module tb_exe_unit_arbiter;

  localparam int M = 4;
  localparam int N = 2;

  logic         clk = 1'b0;
  logic         rsn = 1'b0;
  logic [1:0]   req_valid = 2'b00;
  logic [N-1:0] oper0 = '0, oper1 = '0;
  logic [M-1:0] arga0 = '0, argb0 = '0, arga1 = '0, argb1 = '0;
  logic [1:0]   req_ready;
  logic [N-1:0] exe_oper;
  logic [M-1:0] exe_arga, exe_argb;
  logic [M-1:0] exe_result = '0;
  logic [1:0]   exe_status = '0;
  logic         rsp_valid, rsp_id;
  logic [M-1:0] rsp_result;
  logic [1:0]   rsp_status;
  logic         rsp_ready = 1'b0;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  // clock / reset
  always #5 clk = ~clk;

  exe_unit_arbiter #(.m(M), .n(N)) dut (
    .i_clk        (clk),
    .i_rsn        (rsn),
    .i_req_valid  (req_valid),
    .i_req_oper0  (oper0),
    .i_req_argA0  (arga0),
    .i_req_argB0  (argb0),
    .i_req_oper1  (oper1),
    .i_req_argA1  (arga1),
    .i_req_argB1  (argb1),
    .o_req_ready  (req_ready),
    .o_exe_oper   (exe_oper),
    .o_exe_argA   (exe_arga),
    .o_exe_argB   (exe_argb),
    .i_exe_result (exe_result),
    .i_exe_status (exe_status),
    .o_rsp_valid  (rsp_valid),
    .o_rsp_id     (rsp_id),
    .o_rsp_result (rsp_result),
    .o_rsp_status (rsp_status),
    .i_rsp_ready  (rsp_ready),
    .o_busy       (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rsn = 1'b0;
    step();
    step();
    rsn = 1'b1;
  endtask

  task automatic test_reset();
    req_valid = 2'b00;
    do_reset();
    n_checks++;
    if ({busy, rsp_valid, rsp_id, rsp_result, rsp_status, req_ready} !== 11'b0) begin
      $display("FAIL reset_state: got busy=%b vld=%b id=%b res=%h st=%b rdy=%b, want all 0",
               busy, rsp_valid, rsp_id, rsp_result, rsp_status, req_ready);
      n_fail++;
    end
    n_checks++;
    if ({exe_oper, exe_arga, exe_argb} !== 10'b0) begin
      $display("FAIL reset_operands: got %b, want 0", {exe_oper, exe_arga, exe_argb});
      n_fail++;
    end
  endtask

  // single request, latency, and capture timing
  task automatic test_single();
    req_valid = 2'b01; oper0 = 2'b10; arga0 = 4'h3; argb0 = 4'h5;
    #1;
    n_checks++;
    if (req_ready !== 2'b01) begin
      $display("FAIL single_ready: got %b want 01", req_ready); n_fail++;
    end
    step(); // edge T: accepted, now EXEC
    req_valid = 2'b00; oper0 = 2'b00; arga0 = 4'h0; argb0 = 4'h0;
    n_checks++;
    if ({exe_oper, exe_arga, exe_argb} !== {2'b10, 4'h3, 4'h5}) begin
      $display("FAIL single_exec_ops: got %b/%h/%h want 10/3/5", exe_oper, exe_arga, exe_argb); n_fail++;
    end
    n_checks++;
    if ({busy, req_ready, rsp_valid} !== 4'b1000) begin
      $display("FAIL single_exec_ctl: got busy=%b rdy=%b vld=%b want 1/00/0", busy, req_ready, rsp_valid); n_fail++;
    end
    step(); // T+1: CAPT
    exe_result = 4'hA; exe_status = 2'b01;
    n_checks++;
    if ({exe_oper, exe_arga, exe_argb, rsp_valid} !== {2'b10, 4'h3, 4'h5, 1'b0}) begin
      $display("FAIL single_capt: got %b/%h/%h vld=%b want 10/3/5 vld=0", exe_oper, exe_arga, exe_argb, rsp_valid); n_fail++;
    end
    step(); // T+2: RESP
    exe_result = 4'hF; exe_status = 2'b11;
    n_checks++;
    if ({rsp_valid, rsp_id, rsp_result, rsp_status} !== {1'b1, 1'b0, 4'hA, 2'b01}) begin
      $display("FAIL single_rsp: got vld=%b id=%b res=%h st=%b want 1/0/a/01", rsp_valid, rsp_id, rsp_result, rsp_status); n_fail++;
    end
    step(); // still RESP, unit output moved on
    n_checks++;
    if ({rsp_valid, rsp_result, rsp_status} !== {1'b1, 4'hA, 2'b01}) begin
      $display("FAIL capture_hold: got vld=%b res=%h st=%b want 1/a/01", rsp_valid, rsp_result, rsp_status); n_fail++;
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    n_checks++;
    if ({rsp_valid, busy} !== 2'b00) begin
      $display("FAIL single_done: got vld=%b busy=%b want 0/0", rsp_valid, busy); n_fail++;
    end
  endtask

  task automatic test_contention();
    logic [1:0] exp_rdy [4];
    logic       exp_id  [4];
    exp_rdy[0] = 2'b01; exp_rdy[1] = 2'b10; exp_rdy[2] = 2'b01; exp_rdy[3] = 2'b10;
    exp_id[0]  = 1'b0;  exp_id[1]  = 1'b1;  exp_id[2]  = 1'b0;  exp_id[3]  = 1'b1;
    oper0 = 2'b01; arga0 = 4'h1; argb0 = 4'h2;
    oper1 = 2'b11; arga1 = 4'h7; argb1 = 4'h8;
    req_valid = 2'b11;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (req_ready !== exp_rdy[i]) begin
        $display("FAIL cont_grant%0d: got %b want %b", i, req_ready, exp_rdy[i]); n_fail++;
      end
      step(); // EXEC
      n_checks++;
      if (exe_arga !== (exp_id[i] ? 4'h7 : 4'h1)) begin
        $display("FAIL cont_argA%0d: got %h want %h", i, exe_arga, exp_id[i] ? 4'h7 : 4'h1); n_fail++;
      end
      step(); // CAPT
      exe_result = 4'(i + 4); exe_status = 2'(i);
      step(); // RESP
      n_checks++;
      if ({rsp_id, rsp_result, rsp_status} !== {exp_id[i], 4'(i + 4), 2'(i)}) begin
        $display("FAIL cont_rsp%0d: got id=%b res=%h st=%b want %b/%h/%b",
                 i, rsp_id, rsp_result, rsp_status, exp_id[i], 4'(i + 4), 2'(i)); n_fail++;
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
    end
    req_valid = 2'b00;
  endtask

  task automatic test_back_pressure();
    oper0 = 2'b00; arga0 = 4'h9; argb0 = 4'h6;
    req_valid = 2'b01;
    step(); // EXEC (pointer was 1 after contention, only 0 valid)
    req_valid = 2'b10; // requester 1 waits through the busy period
    step(); // CAPT
    exe_result = 4'hC; exe_status = 2'b10;
    step(); // RESP
    for (int i = 0; i < 5; i++) begin
      exe_result = 4'(i); exe_status = 2'b00;
      n_checks++;
      if ({rsp_valid, rsp_id, rsp_result, rsp_status, req_ready} !== {1'b1, 1'b0, 4'hC, 2'b10, 2'b00}) begin
        $display("FAIL bp_hold%0d: got vld=%b id=%b res=%h st=%b rdy=%b want 1/0/c/10/00",
                 i, rsp_valid, rsp_id, rsp_result, rsp_status, req_ready); n_fail++;
      end
      step();
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    n_checks++;
    if ({busy, rsp_valid, req_ready} !== {1'b0, 1'b0, 2'b10}) begin
      $display("FAIL bp_release: got busy=%b vld=%b rdy=%b want 0/0/10", busy, rsp_valid, req_ready); n_fail++;
    end
    req_valid = 2'b00;
  endtask

  task automatic test_reset_mid_op();
    // Grant requester 1 first so the pointer would otherwise favour 0... then 1.
    req_valid = 2'b10;
    step(); // EXEC, pointer=1
    req_valid = 2'b00;
    step(); // CAPT
    exe_result = 4'h4;
    step(); // RESP
    rsp_ready = 1'b1;
    step(); // IDLE
    rsp_ready = 1'b0;
    req_valid = 2'b01;
    step(); // EXEC with owner 0, pointer=0 (would favour 1 next)
    req_valid = 2'b00;
    rsn = 1'b0;
    step();
    n_checks++;
    if ({busy, rsp_valid} !== 2'b00) begin
      $display("FAIL midrst_state: got busy=%b vld=%b want 0/0", busy, rsp_valid); n_fail++;
    end
    rsn = 1'b1;
    req_valid = 2'b11;
    #1;
    n_checks++;
    if (req_ready !== 2'b01) begin
      $display("FAIL midrst_grant: got %b want 01", req_ready); n_fail++;
    end
    step(); // EXEC owner 0
    req_valid = 2'b00;
    step(); step();
    n_checks++;
    if ({rsp_valid, rsp_id} !== 2'b10) begin
      $display("FAIL midrst_rsp: got vld=%b id=%b want 1/0", rsp_valid, rsp_id); n_fail++;
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_idle_hold();
    req_valid = 2'b00;
    rsp_ready = 1'b1; // ignored outside RESP
    for (int i = 0; i < 10; i++) begin
      step();
      n_checks++;
      if ({busy, rsp_valid, req_ready} !== 4'b0000) begin
        $display("FAIL idle_hold%0d: got busy=%b vld=%b rdy=%b want 0/0/00", i, busy, rsp_valid, req_ready); n_fail++;
      end
    end
    rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_back_pressure();
    test_reset_mid_op();
    test_idle_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
